// File: rtl/nf10_router_pkg.sv
// Shared router definitions: ARP/Ethernet constants, ARP header byte offsets,
// the beat record carried through the ARP responder and its FSM states.
package nf10_router_pkg;

  localparam logic [15:0] ETH_ARP       = 16'h0806;
  localparam logic [15:0] ARP_REQ       = 16'h0001;
  localparam logic [15:0] ARP_REP       = 16'h0002;
  localparam logic [15:0] ARP_HTYPE_ETH = 16'h0001;
  localparam logic [15:0] ETH_IPV4      = 16'h0800;
  localparam logic [7:0]  ARP_HLEN      = 8'd6;
  localparam logic [7:0]  ARP_PLEN      = 8'd4;

  // Frame byte offsets; byte n sits at [255-8*(n%32) -: 8] of its beat.
  localparam int OFF_ETH_DST = 0;
  localparam int OFF_ETH_SRC = 6;
  localparam int OFF_ETHTYPE = 12;
  localparam int OFF_HTYPE   = 14;
  localparam int OFF_PTYPE   = 16;
  localparam int OFF_HLEN    = 18;
  localparam int OFF_PLEN    = 19;
  localparam int OFF_OPER    = 20;
  localparam int OFF_SHA     = 22;
  localparam int OFF_SPA     = 28;
  localparam int OFF_THA     = 32;
  localparam int OFF_TPA     = 38;

  typedef struct packed {
    logic [255:0] data;
    logic [31:0]  strb;
    logic [127:0] user;
    logic         last;
  } beat_t;

  typedef enum logic [2:0] {S_IDLE, S_HDR1, S_EMIT0, S_EMIT1, S_PASS} state_e;

endpackage

// File: rtl/arp_reply_rewrite.sv
// Combinational ARP request classifier and in-place reply rewriter for the
// first two 32-byte beats, given the selected port's MAC and IP.
module arp_reply_rewrite
  import nf10_router_pkg::*;
(
  input  logic [255:0] beat0_i,
  input  logic [255:0] beat1_i,
  input  logic [47:0]  mac_i,
  input  logic [31:0]  ip_i,
  output logic         match_o,
  output logic [255:0] beat0_o,
  output logic [255:0] beat1_o
);
  logic [47:0] sha;
  logic [31:0] spa;

  assign sha = beat0_i[255-8*OFF_SHA -: 48];
  assign spa = beat0_i[255-8*OFF_SPA -: 32];

  assign match_o = (beat0_i[255-8*OFF_ETHTYPE -: 16] == ETH_ARP)
                && (beat0_i[255-8*OFF_HTYPE -: 16]   == ARP_HTYPE_ETH)
                && (beat0_i[255-8*OFF_PTYPE -: 16]   == ETH_IPV4)
                && (beat0_i[255-8*OFF_HLEN -: 8]     == ARP_HLEN)
                && (beat0_i[255-8*OFF_PLEN -: 8]     == ARP_PLEN)
                && (beat0_i[255-8*OFF_OPER -: 16]    == ARP_REQ)
                && (beat1_i[255-8*(OFF_TPA-32) -: 32] == ip_i);

  always_comb begin
    beat0_o = beat0_i;
    beat0_o[255-8*OFF_ETH_DST -: 48] = sha;
    beat0_o[255-8*OFF_ETH_SRC -: 48] = mac_i;
    beat0_o[255-8*OFF_OPER -: 16]    = ARP_REP;
    beat0_o[255-8*OFF_SHA -: 48]     = mac_i;
    beat0_o[255-8*OFF_SPA -: 32]     = ip_i;
    beat1_o = beat1_i;
    beat1_o[255-8*(OFF_THA-32) -: 48] = sha;
    beat1_o[255-8*(OFF_TPA-32) -: 32] = spa;
  end

endmodule

// File: rtl/fallthrough_small_fifo.sv
// Small first-word-fallthrough FIFO: the head entry is visible on dout_o
// whenever the FIFO is not empty; rd_en_i consumes it.
module fallthrough_small_fifo #(
  parameter int WIDTH      = 8,
  parameter int DEPTH_BITS = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] din_i,
  input  logic             wr_en_i,
  input  logic             rd_en_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             empty_o,
  output logic             nearly_full_o
);
  localparam int DEPTH = 1 << DEPTH_BITS;
  localparam logic [DEPTH_BITS:0] CNT_FULL  = (DEPTH_BITS+1)'(DEPTH);
  localparam logic [DEPTH_BITS:0] CNT_NFULL = (DEPTH_BITS+1)'(DEPTH-1);

  logic [WIDTH-1:0]      mem_q [DEPTH];
  logic [DEPTH_BITS-1:0] wr_q, rd_q;
  logic [DEPTH_BITS:0]   cnt_q;
  logic                  wr_ok, rd_ok;

  assign empty_o       = (cnt_q == '0);
  assign nearly_full_o = (cnt_q >= CNT_NFULL);
  assign wr_ok         = wr_en_i && (cnt_q != CNT_FULL);
  assign rd_ok         = rd_en_i && !empty_o;
  assign dout_o        = mem_q[rd_q];

  always_ff @(posedge clk_i) begin
    if (wr_ok) mem_q[wr_q] <= din_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (wr_ok) wr_q <= wr_q + 1'b1;
      if (rd_ok) rd_q <= rd_q + 1'b1;
      case ({wr_ok, rd_ok})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/arp_reply_gen.sv
// ARP responder: turns ARP requests aimed at the ingress port's own IP into
// replies sent back out that port; everything else passes through unchanged.
module arp_reply_gen
  import nf10_router_pkg::*;
#(
  parameter int C_M_AXIS_DATA_WIDTH  = 256,
  parameter int C_S_AXIS_DATA_WIDTH  = 256,
  parameter int C_M_AXIS_TUSER_WIDTH = 128,
  parameter int C_S_AXIS_TUSER_WIDTH = 128,
  parameter int SRC_PORT_POS         = 16,
  parameter int DST_PORT_POS         = 24
) (
  input  logic                              AXI_ACLK,
  input  logic                              AXI_RESETN,
  input  logic [C_S_AXIS_DATA_WIDTH-1:0]    S_AXIS_TDATA,
  input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  S_AXIS_TSTRB,
  input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   S_AXIS_TUSER,
  input  logic                              S_AXIS_TVALID,
  output logic                              S_AXIS_TREADY,
  input  logic                              S_AXIS_TLAST,
  output logic [C_M_AXIS_DATA_WIDTH-1:0]    M_AXIS_TDATA,
  output logic [C_M_AXIS_DATA_WIDTH/8-1:0]  M_AXIS_TSTRB,
  output logic [C_M_AXIS_TUSER_WIDTH-1:0]   M_AXIS_TUSER,
  output logic                              M_AXIS_TVALID,
  input  logic                              M_AXIS_TREADY,
  output logic                              M_AXIS_TLAST,
  input  logic                              REPLY_EN,
  input  logic [191:0]                      IFACE_MAC,
  input  logic [127:0]                      IFACE_IP,
  output logic [31:0]                       REPLY_COUNT
);
  state_e      state_q, state_d;
  beat_t       b0_q, b0_d, b1_q, b1_d, head, in_beat, m_beat;
  logic        match_q, match_d, rdy_q, empty, nfull, pop, m_vld;
  logic [31:0] cnt_q, cnt_d;

  assign in_beat = {S_AXIS_TDATA, S_AXIS_TSTRB, S_AXIS_TUSER, S_AXIS_TLAST};
  // rdy_q keeps TREADY low while reset is asserted.
  assign S_AXIS_TREADY = rdy_q && !nfull;

  fallthrough_small_fifo #(.WIDTH($bits(beat_t)), .DEPTH_BITS(2)) u_fifo (
    .clk_i(AXI_ACLK), .rst_ni(AXI_RESETN), .din_i(in_beat),
    .wr_en_i(S_AXIS_TVALID && S_AXIS_TREADY), .rd_en_i(pop),
    .dout_o(head), .empty_o(empty), .nearly_full_o(nfull)
  );

  logic [7:0]   src;
  logic [3:0]   even;
  logic [1:0]   k;
  logic         src_one, rw_match, match_w;
  logic [47:0]  mac_k;
  logic [31:0]  ip_k;
  logic [7:0]   dst_oh;
  logic [255:0] rw_b0, rw_b1;

  assign src     = b0_q.user[SRC_PORT_POS +: 8];
  assign even    = {src[6], src[4], src[2], src[0]};
  assign src_one = (even != 4'b0) && ((even & (even - 4'b1)) == 4'b0);

  always_comb begin
    case (even)
      4'b0010: k = 2'd1;
      4'b0100: k = 2'd2;
      4'b1000: k = 2'd3;
      default: k = 2'd0;
    endcase
  end

  assign mac_k   = IFACE_MAC[48*k +: 48];
  assign ip_k    = IFACE_IP[32*k +: 32];
  assign dst_oh  = 8'b1 << {k, 1'b0};
  assign match_w = REPLY_EN && src_one && rw_match;

  arp_reply_rewrite u_rw (
    .beat0_i(b0_q.data), .beat1_i(head.data), .mac_i(mac_k), .ip_i(ip_k),
    .match_o(rw_match), .beat0_o(rw_b0), .beat1_o(rw_b1)
  );

  always_comb begin
    state_d = state_q;
    b0_d    = b0_q;
    b1_d    = b1_q;
    match_d = match_q;
    cnt_d   = cnt_q;
    pop     = 1'b0;
    m_vld   = 1'b0;
    m_beat  = b0_q;
    case (state_q)
      S_IDLE: if (!empty) begin
        pop     = 1'b1;
        b0_d    = head;
        match_d = 1'b0;
        state_d = head.last ? S_EMIT0 : S_HDR1;
      end
      // Rewritten beats are registered here, so the port config is sampled once.
      S_HDR1: if (!empty) begin
        pop     = 1'b1;
        b1_d    = head;
        match_d = match_w;
        state_d = S_EMIT0;
        if (match_w) begin
          b0_d.data = rw_b0;
          b0_d.user[DST_PORT_POS +: 8] = dst_oh;
          b1_d.data = rw_b1;
        end
      end
      S_EMIT0: begin
        m_vld = 1'b1;
        if (M_AXIS_TREADY) state_d = b0_q.last ? S_IDLE : S_EMIT1;
      end
      S_EMIT1: begin
        m_vld  = 1'b1;
        m_beat = b1_q;
        if (M_AXIS_TREADY) begin
          if (match_q) cnt_d = cnt_q + 32'd1;
          state_d = b1_q.last ? S_IDLE : S_PASS;
        end
      end
      S_PASS: begin
        m_vld  = !empty;
        m_beat = head;
        if (!empty && M_AXIS_TREADY) begin
          pop = 1'b1;
          if (head.last) state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge AXI_ACLK or negedge AXI_RESETN) begin
    if (!AXI_RESETN) begin
      state_q <= S_IDLE;
      b0_q    <= '0;
      b1_q    <= '0;
      match_q <= 1'b0;
      cnt_q   <= '0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      b0_q    <= b0_d;
      b1_q    <= b1_d;
      match_q <= match_d;
      cnt_q   <= cnt_d;
      rdy_q   <= 1'b1;
    end
  end

  assign M_AXIS_TVALID = m_vld;
  assign M_AXIS_TDATA  = m_beat.data;
  assign M_AXIS_TSTRB  = m_beat.strb;
  assign M_AXIS_TUSER  = m_beat.user;
  assign M_AXIS_TLAST  = m_beat.last;
  assign REPLY_COUNT   = cnt_q;

endmodule
